fp_align_skid_reg: RTL and testbench
====================================

// Module: fp_align_skid_reg
// PURPOSE
//  Elastic pipeline register between the exponent-compare stage and the mantissa-align stage of the FP adder.
//  Carries the major mantissa, the minor mantissa and the exponent difference.
//  A valid/ready handshake on each side and a 2-entry skid buffer let the align stage stall without losing data.
//  Breaks the ready path: in_ready is a registered signal. Adds flush and an occupancy status output.
// PARAMETERS
//  N             32  mantissa field width (N >= 2)
//  E             8   exponent-difference width (E >= 1)
//  ZERO_ON_EMPTY 0   1: q_* outputs forced to 0 while out_valid=0; 0: q_* show the head register
// PORTS
//  clk          in   1  state updates on the falling edge (datapath pipeline convention)
//  reset        in   1  asynchronous, active-high
//  flush        in   1  synchronous discard of all held entries
//  in_valid     in   1  upstream offers {d_ma,d_me,d_diff_expo}
//  in_ready     out  1  block can accept; registered
//  d_ma         in   N  major mantissa
//  d_me         in   N  minor mantissa
//  d_diff_expo  in   E  exponent difference
//  out_valid    out  1  head entry valid
//  out_ready    in   1  downstream accepts head
//  q_ma         out  N  head major mantissa
//  q_me         out  N  head minor mantissa
//  q_diff_expo  out  E  head exponent difference
//  occupancy    out  2  entries held, 0..2
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at the falling clk edge.
//  - Reset: state EMPTY; head and skid registers = 0; out_valid=0, in_ready=1, occupancy=0, q_*=0.
//  - in_valid is ignored while reset is asserted.
//  - States: EMPTY(occ 0), ONE(occ 1, head valid), FULL(occ 2, head+skid valid).
//  - in_ready = (state != FULL); out_valid = (state != EMPTY). Both decode directly from the state register.
//  - EMPTY: push -> ONE, head<=d.
//  - ONE:
//      push & !pop -> FULL, skid<=d.
//      pop & !push -> EMPTY.
//      push & pop  -> ONE, head<=d.
//      neither     -> hold.
//  - FULL: pop -> ONE, head<=skid. No push is possible because in_ready=0.
//  - Latency: 1 falling edge from push to out_valid when empty. Full throughput (1 per cycle) with out_ready held at 1.
//  - Ordering: strict FIFO; payload bits are never modified.
//  - flush: priority over push/pop; next state EMPTY.
//      A push in the same cycle is consumed and dropped.
//      A pop in the same cycle completes normally from the downstream view.
//      Data registers keep their contents unless ZERO_ON_EMPTY=1 masks q_*.
//  - Reset mid-operation: all state and data clear immediately, without waiting for a clock edge.
//  - No data register is written unless a push or a FULL->ONE pop occurs; no X propagation from idle inputs.
// STRUCTURE
//  - fp_add_pkg: typedef struct packed align_payload_t {ma[N], me[N], diff[E]} (defaults N=32, E=8).
//  - fp_add_pkg: enum skid_state_t {S_EMPTY, S_ONE, S_FULL}.
//  - fp_add_pkg: localparams OCC_W=2, FP_MANT_W=32, FP_DIFF_W=8.
//  - Single module: one state always_ff, plus head and skid payload registers.
//  - No sub-module; the skid logic is too small to split.
// TESTING
//  - Reset: hold reset with in_valid=1 -> out_valid=0, in_ready=1, occ=0, q=0; release -> first push is accepted.
//  - Fill:
//      Setup: out_ready=0; push A={0x00800000,0x00400000,8'h03} then B={0x00C00000,0x00100000,8'h01}.
//      After 2 edges: occ=2, in_ready=0, q=A.
//      Then out_ready=1: next edge q=B, occ=1; following edge occ=0.
//  - Stream: out_ready=1 and 8 back-to-back pushes of ma=i -> q_ma=i one edge later; occ stays 1; in_ready never drops.
//  - Push+pop in ONE (head=A, push C) -> next edge q=C, occ=1, skid untouched.
//  - Flush while FULL with in_valid=1 -> next edge out_valid=0, occ=0, input dropped; ZERO_ON_EMPTY=1 shows q=0.
//  - Async reset between edges while FULL -> out_valid=0, occ=0, in_ready=1, q=0 before the next edge.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types for the FP adder pipeline: align-stage payload, skid-buffer state
// encoding and the occupancy decode used by the elastic registers.
package fp_add_pkg;

    localparam int OCC_W     = 2;
    localparam int FP_MANT_W = 32;
    localparam int FP_DIFF_W = 8;

    typedef struct packed {
        logic [FP_MANT_W-1:0] ma;
        logic [FP_MANT_W-1:0] me;
        logic [FP_DIFF_W-1:0] diff;
    } align_payload_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        case (s)
            S_ONE:   return 2'd1;
            S_FULL:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp_align_skid_reg.sv
// Elastic 2-entry skid register between exponent-compare and mantissa-align.
// Both handshake outputs decode straight from the state register, so in_ready is registered.
module fp_align_skid_reg
    import fp_add_pkg::*;
#(
    parameter int N             = FP_MANT_W,
    parameter int E             = FP_DIFF_W,
    parameter bit ZERO_ON_EMPTY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     d_ma,
    input  logic [N-1:0]     d_me,
    input  logic [E-1:0]     d_diff_expo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     q_ma,
    output logic [N-1:0]     q_me,
    output logic [E-1:0]     q_diff_expo,
    output logic [OCC_W-1:0] occupancy
);

    typedef struct packed {
        logic [N-1:0] ma;
        logic [N-1:0] me;
        logic [E-1:0] diff;
    } payload_t;

    skid_state_t state_q, state_d;
    payload_t    head_q, skid_q, d_in, q_out;
    logic        push, pop;
    logic        head_load, head_from_skid, skid_load;

    assign d_in      = '{ma: d_ma, me: d_me, diff: d_diff_expo};
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = occ_of(state_q);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            // Flush wins: an accepted push is dropped, a pop still completes downstream.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d   = S_ONE;
                        head_load = 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        state_d   = S_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d        = S_ONE;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // NOTE: the payload registers are reset because q_* must read zero straight out of reset.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_from_skid) head_q <= skid_q;
            else if (head_load) head_q <= d_in;
            if (skid_load)      skid_q <= d_in;
        end
    end

    assign q_out       = (ZERO_ON_EMPTY && !out_valid) ? '0 : head_q;
    assign q_ma        = q_out.ma;
    assign q_me        = q_out.me;
    assign q_diff_expo = q_out.diff;

endmodule

// File: tb/tb_fp_align_skid_reg.sv
// Scoreboard bench for fp_align_skid_reg: the model is a plain FIFO queue of payloads,
// the monitor compares handshake status and every popped head against it.
module tb_fp_align_skid_reg;

    localparam int N = 32;
    localparam int E = 8;
    localparam int P = 2 * N + E;

    logic         clk = 1'b1;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] d_ma = '0;
    logic [N-1:0] d_me = '0;
    logic [E-1:0] d_diff_expo = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] q_ma;
    logic [N-1:0] q_me;
    logic [E-1:0] q_diff_expo;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;
    logic [P-1:0] model_q[$];

    fp_align_skid_reg #(.N(N), .E(E), .ZERO_ON_EMPTY(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .d_ma(d_ma), .d_me(d_me), .d_diff_expo(d_diff_expo),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_ma(q_ma), .q_me(q_me), .q_diff_expo(q_diff_expo),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: note whether the next falling edge accepts a push, then update the model.
    task automatic tick();
        logic         acc, fl;
        logic [P-1:0] pay;
        @(posedge clk);
        acc = in_valid && in_ready;
        fl  = flush;
        pay = {d_ma, d_me, d_diff_expo};
        @(negedge clk);
        #1;
        if (fl)       model_q.delete();
        else if (acc) model_q.push_back(pay);
    endtask

    task automatic drive(input logic v, input logic [P-1:0] p, input logic ordy, input logic fl);
        in_valid = v;
        {d_ma, d_me, d_diff_expo} = p;
        out_ready = ordy;
        flush = fl;
    endtask

    // Monitor: status against model size, head against model front on every pop.
    always @(posedge clk) begin
        if (!reset) begin
            check("occupancy", 128'(occupancy), 128'(model_q.size()));
            check("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
            check("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
            if (model_q.size() == 0) begin
                check("q_zero_empty", 128'({q_ma, q_me, q_diff_expo}), 128'(0));
            end else begin
                check("q_head", 128'({q_ma, q_me, q_diff_expo}), 128'(model_q[0]));
                if (out_ready) void'(model_q.pop_front());
            end
        end
    end

    logic [P-1:0] pa, pb, pc, px;

    initial begin
        pa = {32'h0080_0000, 32'h0040_0000, 8'h03};
        pb = {32'h00C0_0000, 32'h0010_0000, 8'h01};
        pc = {32'h1234_5678, 32'h0BAD_F00D, 8'h7E};
        px = {32'hCAFE_0001, 32'h0000_BEEF, 8'h11};

        // Reset held with in_valid high: nothing is captured.
        drive(1'b1, px, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_occ", 128'(occupancy), 128'(0));
        check("rst_q", 128'({q_ma, q_me, q_diff_expo}), 128'(0));
        #1 reset = 1'b0;
        tick();
        check("first_push_valid", 128'(out_valid), 128'(1));
        check("first_push_q", 128'({q_ma, q_me, q_diff_expo}), 128'(px));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("first_drain_occ", 128'(occupancy), 128'(0));

        // Fill with out_ready low, then drain in order.
        drive(1'b1, pa, 1'b0, 1'b0); tick();
        drive(1'b1, pb, 1'b0, 1'b0); tick();
        check("fill_occ", 128'(occupancy), 128'(2));
        check("fill_in_ready", 128'(in_ready), 128'(0));
        check("fill_q", 128'({q_ma, q_me, q_diff_expo}), 128'(pa));
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        check("drain1_q", 128'({q_ma, q_me, q_diff_expo}), 128'(pb));
        check("drain1_occ", 128'(occupancy), 128'(1));
        tick();
        check("drain2_occ", 128'(occupancy), 128'(0));

        // Back-to-back stream at full throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, {N'(i), N'(i * 3), E'(i)}, 1'b1, 1'b0);
            tick();
            check("stream_q_ma", 128'(q_ma), 128'(i));
            check("stream_occ", 128'(occupancy), 128'(1));
            check("stream_in_ready", 128'(in_ready), 128'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();

        // Push and pop together while holding one entry.
        drive(1'b1, pa, 1'b0, 1'b0); tick();
        drive(1'b1, pc, 1'b1, 1'b0); tick();
        check("pushpop_q", 128'({q_ma, q_me, q_diff_expo}), 128'(pc));
        check("pushpop_occ", 128'(occupancy), 128'(1));
        drive(1'b0, '0, 1'b1, 1'b0); tick();

        // Flush while full with a push offered: everything dropped.
        drive(1'b1, pa, 1'b0, 1'b0); tick();
        drive(1'b1, pb, 1'b0, 1'b0); tick();
        drive(1'b1, pc, 1'b0, 1'b1); tick();
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_occ", 128'(occupancy), 128'(0));
        check("flush_q", 128'({q_ma, q_me, q_diff_expo}), 128'(0));
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        check("flush_dropped", 128'(occupancy), 128'(0));

        // Asynchronous reset between edges while full.
        drive(1'b1, pa, 1'b0, 1'b0); tick();
        drive(1'b1, pb, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        model_q.delete();
        #1;
        check("areset_out_valid", 128'(out_valid), 128'(0));
        check("areset_occ", 128'(occupancy), 128'(0));
        check("areset_in_ready", 128'(in_ready), 128'(1));
        check("areset_q", 128'({q_ma, q_me, q_diff_expo}), 128'(0));
        @(negedge clk); #2 reset = 1'b0;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom, 8'($urandom)},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
            tick();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) tick();
        check("final_occ", 128'(occupancy), 128'(0));
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
